cpu_bus_sequencer: RTL
======================

Name: cpu_bus_sequencer

Overview:
- Sits between the 5401 CPU core's 8 output pins and a nibble-wide program/data memory.
- Decodes the CPU's per-cycle strobes (MAR, WRITE, JMP, I) into addressing, memory read/write transactions and program-counter updates.
- Returns instruction nibbles to the CPU data inputs.
- Stalls the CPU through a clock-enable while a memory transaction is outstanding.

Parameters:
- NIBBLES, 3, number of 4-bit nibbles in an address; ADDR_W = 4*NIBBLES.
- TIMEOUT, 15, maximum stall cycles waiting for mem_ack before abort; range 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- cpu_out  in  8  CPU output bits: [3:0] data/RR, [4] MAR, [5] WRITE, [6] JMP, [7] I.
- cpu_in  out  4  nibble driven onto CPU D0..D3.
- cpu_clk_en  out  1  CPU advances only in cycles where this is 1.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  4  write data.
- mem_rdata  in  4  read data, valid with mem_ack.
- mem_ack  in  1  completes the outstanding request.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high while a transaction is outstanding.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async on RST=0):
  - pc=0, addr_reg=0, cpu_in=0, cpu_clk_en=1.
  - mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
  - busy=0, err=0, stall counter=0, state=IDLE.
- Reset mid-transaction aborts immediately with no completion.
- States: IDLE, FETCH, WRITE.
- In IDLE, cpu_out is sampled every cycle while cpu_clk_en=1. Decode priority is JMP > WRITE > MAR > I; only the highest-priority strobe acts.
- JMP: pc <= addr_reg next cycle. No memory access, no stall.
- MAR: addr_reg <= {addr_reg[ADDR_W-5:0], cpu_out[3:0]}.
  - Shift register; the oldest nibble is discarded, no nibble counter.
- WRITE: next cycle enter WRITE with mem_wr=1, mem_addr=addr_reg, mem_wdata=cpu_out[3:0] (captured), cpu_clk_en=0, busy=1.
- I: next cycle enter FETCH with mem_rd=1, mem_addr=pc, cpu_clk_en=0, busy=1.
- While in FETCH or WRITE:
  - mem_rd/mem_wr, mem_addr and mem_wdata are held stable until the request completes.
  - cpu_out is ignored.
- Completion on mem_ack=1:
  - Next cycle: request deasserted, busy=0, cpu_clk_en=1, state=IDLE.
  - FETCH only: cpu_in <= mem_rdata; pc <= pc+1, wrapping modulo 2^ADDR_W.
- The stall counter increments each cycle in FETCH/WRITE without ack. At count == TIMEOUT:
  - The request is dropped and err is set (sticky until reset).
  - FETCH only: cpu_in <= 4'h0 (NOP) and pc still increments.
  - Return to IDLE as for a normal completion.
- mem_ack in the same cycle the counter reaches TIMEOUT counts as a normal ack; err is not set.
- mem_ack while in IDLE is ignored.
- cpu_in holds its last value until the next completed fetch.
- Total latency for a fetch with 1-cycle memory: strobe sampled at cycle N, request at N+1, ack at N+1, cpu_in valid and cpu_clk_en=1 at N+2.

Decomposition:
- Shared package holds:
  - cpu_out bit-index constants (DATA_LSB=0, MAR_BIT=4, WRITE_BIT=5, JMP_BIT=6, I_BIT=7).
  - State enum {IDLE, FETCH, WRITE}.
  - NOP_OPCODE=4'h0.
- One natural sub-module: mem_req_timer, the stall counter with TIMEOUT compare and abort pulse.
- Everything else stays in cpu_bus_sequencer.

Test Plan:
- Address load then jump:
  - Stimulus: reset, then MAR with nibbles 0xA, 0x5, 0x3, then JMP.
  - Required: addr_reg=0xA53, pc=0xA53 one cycle after JMP, cpu_clk_en stays 1.
- Fetch, 1-cycle ack:
  - Stimulus: pc=0x010, mem_rdata=0x7, I strobe.
  - Required: mem_rd=1 with mem_addr=0x010 for exactly 1 cycle; then cpu_in=0x7, pc=0x011, cpu_clk_en back to 1.
- Write with 4-cycle ack:
  - Stimulus: addr_reg=0x123, WRITE with data 0xC.
  - Required: mem_wr=1, mem_addr=0x123, mem_wdata=0xC held stable for 4 cycles; cpu_clk_en=0 throughout; busy drops after ack.
- Timeout:
  - Stimulus: TIMEOUT=15, I strobe, ack never asserted.
  - Required: mem_rd drops after 15 stall cycles, err=1, cpu_in=0x0, pc increments; err stays 1 after further successful fetches.
- PC wrap and strobe priority:
  - Stimulus 1: pc=0xFFF, fetch completes. Required: pc=0x000.
  - Stimulus 2: JMP and I asserted together. Required: only pc load happens, no mem_rd.
- Async reset mid-fetch:
  - Stimulus: RST=0 while in FETCH with mem_rd=1.
  - Required: mem_rd=0, cpu_clk_en=1, pc=0, busy=0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/cpu_bus_sequencer_pkg.sv
// cpu_bus_sequencer_pkg: strobe bit positions, sequencer states and the NOP nibble
package cpu_bus_sequencer_pkg;
  localparam int DATA_LSB = 0;
  localparam int MAR_BIT = 4;
  localparam int WRITE_BIT = 5;
  localparam int JMP_BIT = 6;
  localparam int I_BIT = 7;
  localparam logic [3:0] NOP_OPCODE = 4'h0;
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
endpackage

// File: rtl/cpu_bus_sequencer_if.sv
// cpu_bus_sequencer_if: CPU pin bundle plus nibble memory request bus
interface cpu_bus_sequencer_if #(parameter int NIBBLES = 3);
  localparam int ADDR_W = 4 * NIBBLES;
  logic [7:0] cpu_out;
  logic [3:0] cpu_in;
  logic cpu_clk_en;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd;
  logic mem_wr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic mem_ack;
  modport master(input cpu_out, mem_rdata, mem_ack, output cpu_in, cpu_clk_en, mem_addr, mem_rd, mem_wr, mem_wdata);
  modport slave(output cpu_out, mem_rdata, mem_ack, input cpu_in, cpu_clk_en, mem_addr, mem_rd, mem_wr, mem_wdata);
endinterface

// File: rtl/cpu_bus_sequencer_mem_req_timer.sv
// cpu_bus_sequencer_mem_req_timer: counts unacked request cycles and pulses abort on the TIMEOUT-th one
module cpu_bus_sequencer_mem_req_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_abort
);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt;
  // r_cnt holds completed stall cycles, so the current cycle is number r_cnt+1
  assign o_abort = i_active && !i_ack && r_cnt == LAST;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= (i_active && !i_ack && !o_abort) ? r_cnt + 8'd1 : '0;
endmodule

// File: rtl/cpu_bus_sequencer.sv
// cpu_bus_sequencer: decodes CPU strobes into addressing, PC updates and stalled nibble memory transactions
module cpu_bus_sequencer
  import cpu_bus_sequencer_pkg::*;
#(
  parameter int NIBBLES = 3,
  parameter int TIMEOUT = 15,
  localparam int ADDR_W = 4 * NIBBLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  cpu_bus_sequencer_if.master bus,
  output logic [ADDR_W-1:0] o_pc,
  output logic o_busy,
  output logic o_err
);
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, w_pc_nx, r_addr, w_addr_nx, r_mem_addr, w_mem_addr_nx;
  logic [3:0] r_cpu_in, w_cpu_in_nx, r_wdata, w_wdata_nx, w_data;
  logic r_err, w_err_nx, w_abort, w_done;
  assign w_data = bus.cpu_out[DATA_LSB +: 4];
  assign w_done = bus.mem_ack || w_abort;
  cpu_bus_sequencer_mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_active(r_state != IDLE),
    .i_ack(bus.mem_ack),
    .o_abort(w_abort)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_addr <= '0;
      r_mem_addr <= '0;
      r_cpu_in <= '0;
      r_wdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      r_addr <= w_addr_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_cpu_in <= w_cpu_in_nx;
      r_wdata <= w_wdata_nx;
      r_err <= w_err_nx;
    end
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = r_pc;
    w_addr_nx = r_addr;
    w_mem_addr_nx = r_mem_addr;
    w_cpu_in_nx = r_cpu_in;
    w_wdata_nx = r_wdata;
    w_err_nx = r_err;
    if (r_state == IDLE) begin
      if (bus.cpu_out[JMP_BIT]) w_pc_nx = r_addr;
      else if (bus.cpu_out[WRITE_BIT]) begin
        w_state_nx = WRITE;
        w_mem_addr_nx = r_addr;
        w_wdata_nx = w_data;
      end else if (bus.cpu_out[MAR_BIT]) w_addr_nx = {r_addr[ADDR_W-5:0], w_data};
      else if (bus.cpu_out[I_BIT]) begin
        w_state_nx = FETCH;
        w_mem_addr_nx = r_pc;
      end
    end else if (w_done) begin
      w_state_nx = IDLE;
      w_err_nx = r_err || w_abort;
      if (r_state == FETCH) begin
        w_cpu_in_nx = bus.mem_ack ? bus.mem_rdata : NOP_OPCODE;
        w_pc_nx = r_pc + 1'b1;
      end
    end
  end
  assign bus.cpu_in = r_cpu_in;
  assign bus.cpu_clk_en = r_state == IDLE;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rd = r_state == FETCH;
  assign bus.mem_wr = r_state == WRITE;
  assign bus.mem_wdata = r_wdata;
  assign o_pc = r_pc;
  assign o_busy = r_state != IDLE;
  assign o_err = r_err;
endmodule
